// File: rtl/sram_stream_pkg.sv
// ============================================================================
// Module  : sram_stream_pkg
// Purpose : Shared state encoding and default widths for the SRAM stream packer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_stream_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_pack_shreg.sv
// ============================================================================
// Module  : sram_pack_shreg
// Purpose : Shift/pack register; the first word shifted in lands in the MSBs
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_pack_shreg
    import sram_stream_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int PACK   = 4
) (
    input  logic                     CLK,
    input  logic                     clr,
    input  logic                     shift_en,
    input  logic [DATA_W-1:0]        in_data,
    output logic [DATA_W*PACK-1:0]   pack,
    output logic                     last
);

    localparam int c_SRAM_W = DATA_W * PACK;
    localparam int c_SEL_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [c_SEL_W-1:0] c_SEL_MAX = c_SEL_W'(PACK - 1);

    logic [c_SEL_W-1:0]  r_sel;
    logic [c_SRAM_W-1:0] r_pack;
    logic [c_SRAM_W-1:0] w_shifted;

    generate
        if (PACK == 1) begin : g_single
            assign w_shifted = in_data;
        end else begin : g_multi
            assign w_shifted = {r_pack[c_SRAM_W-DATA_W-1:0], in_data};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (clr) begin
            r_sel  <= '0;
            r_pack <= '0;
        end else if (shift_en) begin
            r_pack <= w_shifted;
            r_sel  <= (r_sel == c_SEL_MAX) ? '0 : r_sel + c_SEL_W'(1);
        end
    end

    assign pack = r_pack;
    assign last = (r_sel == c_SEL_MAX);

endmodule

`default_nettype wire

// File: rtl/sram_stream_packer.sv
// ============================================================================
// Module  : sram_stream_packer
// Purpose : Packs PACK narrow stream words per SRAM word and writes them out
//           at auto-incrementing addresses for a programmed word count
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_stream_packer
    import sram_stream_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int PACK   = 4,
    parameter int ADDR_W = c_ADDR_W,
    parameter int CNT_W  = 20
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     enable,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [CNT_W-1:0]         word_cnt,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic [ADDR_W-1:0]        SRAM_ADDR_Stream,
    output logic [DATA_W*PACK-1:0]   SRAM_DATA_IN_Stream,
    output logic                     SRAM_WE,
    output logic                     busy,
    output logic                     done
);

    localparam int SRAM_W = DATA_W * PACK;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clr;
    logic               w_hs;
    logic               w_last;
    logic [SRAM_W-1:0]  w_pack;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_addr_hold;
    logic [CNT_W-1:0]   r_remain;
    logic [SRAM_W-1:0]  r_data_hold;

    assign w_clr = !RSTn || !enable;
    assign w_hs  = (r_state == FILL) && in_valid;

    sram_pack_shreg #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_shreg (
        .CLK      (CLK),
        .clr      (w_clr),
        .shift_en (w_hs),
        .in_data  (in_data),
        .pack     (w_pack),
        .last     (w_last)
    );

    always_ff @(posedge CLK) begin
        if (w_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (word_cnt == '0) ? DONE : FILL;
            FILL:    if (w_hs && w_last) w_state_nxt = WRITE;
            WRITE:   w_state_nxt = (r_remain == CNT_W'(1)) ? DONE : FILL;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Hold registers keep the last written address/data visible outside WRITE.
    always_ff @(posedge CLK) begin
        if (w_clr) begin
            r_addr      <= '0;
            r_remain    <= '0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_addr   <= base_addr;
                r_remain <= word_cnt;
            end
            if (r_state == WRITE) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remain    <= r_remain - CNT_W'(1);
                r_addr_hold <= r_addr;
                r_data_hold <= w_pack;
            end
        end
    end

    assign in_ready            = (r_state == FILL);
    assign SRAM_WE             = (r_state == WRITE);
    assign busy                = (r_state != IDLE);
    assign done                = (r_state == DONE);
    assign SRAM_ADDR_Stream    = SRAM_WE ? r_addr : r_addr_hold;
    assign SRAM_DATA_IN_Stream = SRAM_WE ? w_pack : r_data_hold;

endmodule

`default_nettype wire

// File: tb/tb_sram_stream_packer.sv
// ============================================================================
// Module  : tb_sram_stream_packer
// Purpose : Randomised self-checking bench for sram_stream_packer (PACK=4, PACK=1)
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_stream_packer;

    localparam int DW = 32;
    localparam int AW = 19;
    localparam int CW = 20;

    logic          CLK       = 1'b0;
    logic          RSTn      = 1'b0;
    logic          enable    = 1'b0;
    logic          start     = 1'b0;
    logic          sel_b     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_cnt  = '0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;

    logic           start_a, start_b;
    logic           rdy_a, we_a, busy_a, done_a;
    logic           rdy_b, we_b, busy_b, done_b;
    logic [AW-1:0]  addr_a, addr_b;
    logic [127:0]   data_a;
    logic [31:0]    data_b;

    logic           o_rdy, o_we, o_busy, o_done;
    logic [AW-1:0]  o_addr;
    logic [127:0]   o_data;

    assign start_a = start && !sel_b;
    assign start_b = start && sel_b;

    sram_stream_packer #(.DATA_W(DW), .PACK(4), .ADDR_W(AW), .CNT_W(CW)) u_dut_a (
        .CLK(CLK), .RSTn(RSTn), .enable(enable), .start(start_a),
        .base_addr(base_addr), .word_cnt(word_cnt), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .SRAM_ADDR_Stream(addr_a), .SRAM_DATA_IN_Stream(data_a),
        .SRAM_WE(we_a), .busy(busy_a), .done(done_a)
    );

    sram_stream_packer #(.DATA_W(DW), .PACK(1), .ADDR_W(AW), .CNT_W(CW)) u_dut_b (
        .CLK(CLK), .RSTn(RSTn), .enable(enable), .start(start_b),
        .base_addr(base_addr), .word_cnt(word_cnt), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .SRAM_ADDR_Stream(addr_b), .SRAM_DATA_IN_Stream(data_b),
        .SRAM_WE(we_b), .busy(busy_b), .done(done_b)
    );

    assign o_rdy  = sel_b ? rdy_b  : rdy_a;
    assign o_we   = sel_b ? we_b   : we_a;
    assign o_busy = sel_b ? busy_b : busy_a;
    assign o_done = sel_b ? done_b : done_a;
    assign o_addr = sel_b ? addr_b : addr_a;
    assign o_data = sel_b ? {96'b0, data_b} : data_a;

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: expected outputs for the coming cycle, derived from transfer rules.
    bit            armed = 0;
    bit            e_rdy = 0, e_we = 0, e_done = 0, e_busy = 0;
    logic [AW-1:0] e_addr = '0;
    logic [127:0]  e_data = '0;
    logic [AW-1:0] m_addr = '0;
    int            m_left = 0;
    logic [31:0]   m_q[$];
    logic [AW-1:0] log_addr[$];
    logic [127:0]  log_data[$];
    int            log_cyc[$];
    int            cyc = 0;
    int            busy_cycles = 0;

    always @(negedge CLK) begin
        bit           nr, nw, nd, nb;
        int           mp;
        logic [127:0] w;
        cyc++;
        mp = sel_b ? 1 : 4;
        if (armed) begin
            check("in_ready", o_rdy, e_rdy);
            check("sram_we", o_we, e_we);
            check("done", o_done, e_done);
            check("busy", o_busy, e_busy);
            check("sram_addr", o_addr, e_addr);
            check("sram_data", o_data, e_data);
        end
        if (o_we) begin
            log_addr.push_back(o_addr);
            log_data.push_back(o_data);
            log_cyc.push_back(cyc);
        end
        if (o_busy) busy_cycles++;

        nr = 0; nw = 0; nd = 0; nb = 0;
        if (!RSTn || !enable) begin
            m_q.delete();
            e_addr = '0;
            e_data = '0;
        end else if (e_done) begin
            // transfer ends; back to idle
        end else if (!e_busy) begin
            if (start) begin
                m_addr = base_addr;
                m_left = int'(word_cnt);
                nb = 1;
                if (word_cnt == '0) nd = 1;
                else nr = 1;
            end
        end else if (e_we) begin
            m_left = m_left - 1;
            m_addr = m_addr + 1'b1;
            nb = 1;
            if (m_left == 0) nd = 1;
            else nr = 1;
        end else begin
            nb = 1;
            if (in_valid) begin
                m_q.push_back(in_data);
                if (m_q.size() == mp) begin
                    w = '0;
                    foreach (m_q[i]) w[(mp-1-i)*32 +: 32] = m_q[i];
                    e_addr = m_addr;
                    e_data = w;
                    m_q.delete();
                    nw = 1;
                end else begin
                    nr = 1;
                end
            end else begin
                nr = 1;
            end
        end
        e_rdy = nr; e_we = nw; e_done = nd; e_busy = nb;
        armed = 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int c);
        base_addr = b;
        word_cnt  = CW'(c);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = AW'($urandom);
        word_cnt  = CW'($urandom);
    endtask

    task automatic feed(input logic [31:0] words[$], input int stall_pct, input bit pulse_start);
        int i = 0;
        int budget = 0;
        bit hs;
        while (i < words.size()) begin
            in_valid = ($urandom_range(99) >= stall_pct);
            in_data  = in_valid ? words[i] : $urandom;
            start    = pulse_start && (i == 1);
            @(negedge CLK);
            hs = in_valid && o_rdy;
            tick();
            if (hs) i++;
            budget++;
            if (budget > 2000) begin
                timeout_fail("feed");
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge CLK);
            if (!o_busy) break;
            n++;
            if (n > 300) begin
                timeout_fail("wait_idle");
                break;
            end
        end
        tick();
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    logic [31:0] wq[$];
    logic [31:0] ws[$];

    initial begin
        #1;
        enable = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        check("rst_addr_a", addr_a, '0);
        check("rst_data_a", data_a, '0);
        check("rst_ctrl_a", {we_a, rdy_a, busy_a, done_a}, 4'b0000);
        check("rst_addr_b", addr_b, '0);
        check("rst_data_b", data_b, '0);
        check("rst_ctrl_b", {we_b, rdy_b, busy_b, done_b}, 4'b0000);
        RSTn = 1'b1;
        tick();

        // Basic: words 1..8 back-to-back
        wq.delete();
        for (int k = 1; k <= 8; k++) wq.push_back(32'(k));
        for (int pass = 0; pass < 2; pass++) begin
            clear_log();
            do_start(19'h00100, 2);
            feed(wq, pass == 0 ? 0 : 40, 1'b0);
            wait_idle();
            check("basic_nwr", log_addr.size(), 2);
            if (log_addr.size() == 2) begin
                check("basic_a0", log_addr[0], 19'h00100);
                check("basic_d0", log_data[0], 128'h00000001_00000002_00000003_00000004);
                check("basic_a1", log_addr[1], 19'h00101);
                check("basic_d1", log_data[1], 128'h00000005_00000006_00000007_00000008);
                if (pass == 0) check("basic_gap", log_cyc[1] - log_cyc[0], 5);
            end
        end

        // Address wrap
        wq.delete();
        for (int k = 0; k < 8; k++) wq.push_back($urandom);
        clear_log();
        do_start(19'h7FFFF, 2);
        feed(wq, 20, 1'b0);
        wait_idle();
        check("wrap_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("wrap_a0", log_addr[0], 19'h7FFFF);
            check("wrap_a1", log_addr[1], 19'h00000);
            check("wrap_d0", log_data[0], {wq[0], wq[1], wq[2], wq[3]});
        end

        // Zero count
        clear_log();
        busy_cycles = 0;
        do_start(19'h00055, 0);
        repeat (3) tick();
        check("zero_nwr", log_addr.size(), 0);
        check("zero_busy", busy_cycles, 1);

        // Abort after 2 of 4 words, then a clean transfer
        ws.delete();
        ws.push_back(32'hDEAD0001);
        ws.push_back(32'hDEAD0002);
        do_start(19'h00040, 1);
        feed(ws, 0, 1'b0);
        enable = 1'b0;
        tick();
        @(negedge CLK);
        check("abort_ctrl", {we_a, rdy_a, busy_a, done_a}, 4'b0000);
        check("abort_addr", addr_a, '0);
        check("abort_data", data_a, '0);
        enable = 1'b1;
        tick();
        clear_log();
        wq.delete();
        wq.push_back(32'hA0A0A0A0); wq.push_back(32'hB1B1B1B1);
        wq.push_back(32'hC2C2C2C2); wq.push_back(32'hD3D3D3D3);
        do_start(19'h00020, 1);
        feed(wq, 0, 1'b0);
        wait_idle();
        check("fresh_nwr", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check("fresh_a0", log_addr[0], 19'h00020);
            check("fresh_d0", log_data[0], 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
        end

        // Random transfers with stalls
        for (int t = 0; t < 6; t++) begin
            int cnt;
            cnt = $urandom_range(3, 1);
            wq.delete();
            for (int k = 0; k < cnt * 4; k++) wq.push_back($urandom);
            clear_log();
            do_start(AW'($urandom), cnt);
            feed(wq, 30, 1'b0);
            wait_idle();
            check("rand_nwr", log_addr.size(), cnt);
        end

        // PACK=1 instance; clear both first so hold registers agree with the model
        enable = 1'b0;
        tick();
        sel_b  = 1'b1;
        enable = 1'b1;
        tick();
        clear_log();
        wq.delete();
        wq.push_back(32'h11111111); wq.push_back(32'h22222222); wq.push_back(32'h33333333);
        do_start(19'h00005, 3);
        feed(wq, 0, 1'b1);
        wait_idle();
        check("p1_nwr", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            check("p1_a2", log_addr[2], 19'h00007);
            check("p1_d1", log_data[1], 128'h22222222);
            check("p1_gap0", log_cyc[1] - log_cyc[0], 2);
            check("p1_gap1", log_cyc[2] - log_cyc[1], 2);
        end

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/sram_stream_packer.md
# sram_stream_packer

Parametrised stream-to-SRAM write engine for SRAM initialisation and bulk loading. It accepts narrow data words over a valid/ready handshake and packs `PACK` of them into one wide SRAM word. It issues one write strobe per packed word at an auto-incrementing address, starting from a programmable base, for a programmable number of SRAM words. It sits between the host/DMA data source and the SRAM controller write port.

## Interface
Parameters:
- `DATA_W`, 32, width of one input word
- `PACK`, 4, input words per SRAM word (≥1); `SRAM_W = DATA_W*PACK` (localparam)
- `ADDR_W`, 19, SRAM address width
- `CNT_W`, 20, width of the SRAM-word count

Ports (reset is synchronous, active-low on `RSTn`; clock `CLK`):
- `CLK` in 1, clock
- `RSTn` in 1, synchronous active-low reset
- `enable` in 1, block enable; low = synchronous clear
- `start` in 1, one-cycle pulse that launches a transfer
- `base_addr` in `ADDR_W`, first SRAM address, sampled on `start`
- `word_cnt` in `CNT_W`, SRAM words to write, sampled on `start`
- `in_valid` in 1, input word valid
- `in_data` in `DATA_W`, input word
- `in_ready` out 1, block can accept `in_data`
- `SRAM_ADDR_Stream` out `ADDR_W`, write address
- `SRAM_DATA_IN_Stream` out `SRAM_W`, packed write data
- `SRAM_WE` out 1, write strobe, one cycle per SRAM word
- `busy` out 1, transfer in progress
- `done` out 1, one-cycle pulse at end of transfer

## Operation
- States:
  - IDLE: `in_ready`=0. `start`&&`enable` captures `base_addr`/`word_cnt`. Goes to DONE if `word_cnt`==0, else to FILL.
  - FILL: `in_ready`=1. Each handshake (`in_valid`&&`in_ready`) shifts data with `pack <= (pack << DATA_W) | in_data` and increments `sel` (0..PACK-1). On the handshake with `sel`==PACK-1 the state goes to WRITE and `sel` returns to 0.
  - WRITE: `in_ready`=0. `SRAM_WE`=1 for exactly this cycle, `SRAM_DATA_IN_Stream`=packed word, `SRAM_ADDR_Stream`=current address. Exit decrements remaining count and increments address. Goes to DONE if remaining becomes 0, else to FILL.
  - DONE: `done`=1 for one cycle, then IDLE.
- Packing order: the first accepted word ends in the MSBs (`[SRAM_W-1 -: DATA_W]`) and the last accepted word in the LSBs.
- Address arithmetic is modulo 2^`ADDR_W`: the address after the all-ones address is 0, with no error.
- `busy` = state ≠ IDLE.
- `start` outside IDLE is ignored.
- `enable` low in any state: next cycle is IDLE, with all outputs, `sel` and `pack` at reset values. A partially packed word is discarded and no write is issued.
- `RSTn` low mid-transfer: same result as `enable` low.
- `in_valid` may stall arbitrarily in FILL; the block holds state. `in_data` is ignored when not handshaking.

## Timing
- Reset values: `SRAM_ADDR_Stream`=0, `SRAM_DATA_IN_Stream`=0, `SRAM_WE`=0, `in_ready`=0, `busy`=0, `done`=0, state IDLE.
- All outputs are registered or decoded from the state register only; there is no combinational input-to-output path.
- `start` at edge t → FILL and `in_ready`=1 from cycle t+1.
- Last (`PACK`-th) handshake at edge t → `SRAM_WE`=1 with valid address and data in cycle t+1. `in_ready`=1 again in cycle t+2.
- Throughput: `PACK` input words per `PACK`+1 cycles at best.
- Final WRITE in cycle t → `done`=1 in cycle t+1 → IDLE (`busy`=0) in cycle t+2.
- `start` with `word_cnt`=0 at edge t → `done` in cycle t+1, no `SRAM_WE`.
- `SRAM_ADDR_Stream`/`SRAM_DATA_IN_Stream` hold their last written values outside WRITE (until clear).

## Structure
- Shared package/header `sram_stream_pkg`:
  - state encoding (IDLE=0, FILL=1, WRITE=2, DONE=3)
  - default widths (`DATA_W`, `ADDR_W`)
- One sub-module, `sram_pack_shreg`, holds the shift/pack register and `sel` counter. It has ports `clr`, `shift_en`, `in_data`, `pack`, `last`. The FSM, address counter and remaining counter stay in the top.

## Test plan
- Basic: `PACK`=4, base 0x100, `word_cnt`=2, words 1..8 back-to-back → writes at 0x100 with data 0x00000001_00000002_00000003_00000004 and at 0x101 with data 0x…05_…06_…07_…08. `done` one cycle after the second WE.
- Stalls: same stimulus with `in_valid` toggled randomly → identical writes. `SRAM_WE` exactly 2 pulses. No words lost or duplicated.
- Wrap: base 0x7FFFF, `word_cnt`=2 → writes at 0x7FFFF then 0x00000.
- Zero count: `start` with `word_cnt`=0 → `done` next cycle, no WE, `busy` high exactly one cycle.
- Abort: `enable` low after 2 of 4 words → next cycle IDLE with all outputs 0. A fresh `start` then produces a correct write with no residue from the stale words.
- `PACK`=1, `DATA_W`=32: 3 words → 3 writes, each 2 cycles apart. `start` pulsed while busy → ignored.
